// File: rtl/el2_mem_init_ctrl.sv
// Zero-fill sequencer for ICCM/DCCM SRAM banks: owns the macro ports while writing
// all-zero data/ECC to every row, otherwise passes the core's SRAM controls straight through.
module el2_mem_init_ctrl #(
  parameter int ICCM_ENABLE     = 1,
  parameter int ICCM_NUM_BANKS  = 4,
  parameter int ICCM_ADDR_W     = 12,
  parameter int ICCM_ECC_WIDTH  = 7,
  parameter int DCCM_ENABLE     = 1,
  parameter int DCCM_NUM_BANKS  = 4,
  parameter int DCCM_ADDR_W     = 10,
  parameter int DCCM_DATA_WIDTH = 32,
  parameter int DCCM_ECC_WIDTH  = 7,
  parameter int AUTO_START      = 1
) (
  input  logic                                      clk,
  input  logic                                      rst_l,
  input  logic                                      init_req,
  output logic                                      busy,
  output logic                                      done,
  input  logic [ICCM_NUM_BANKS-1:0]                 c_iccm_clken_bank,
  input  logic [ICCM_NUM_BANKS-1:0]                 c_iccm_wren_bank,
  input  logic [ICCM_NUM_BANKS*ICCM_ADDR_W-1:0]     c_iccm_addr_bank,
  input  logic [ICCM_NUM_BANKS*32-1:0]              c_iccm_wr_data_bank,
  input  logic [ICCM_NUM_BANKS*ICCM_ECC_WIDTH-1:0]  c_iccm_wr_ecc_bank,
  output logic [ICCM_NUM_BANKS-1:0]                 m_iccm_clken_bank,
  output logic [ICCM_NUM_BANKS-1:0]                 m_iccm_wren_bank,
  output logic [ICCM_NUM_BANKS*ICCM_ADDR_W-1:0]     m_iccm_addr_bank,
  output logic [ICCM_NUM_BANKS*32-1:0]              m_iccm_wr_data_bank,
  output logic [ICCM_NUM_BANKS*ICCM_ECC_WIDTH-1:0]  m_iccm_wr_ecc_bank,
  input  logic [DCCM_NUM_BANKS-1:0]                 c_dccm_clken_bank,
  input  logic [DCCM_NUM_BANKS-1:0]                 c_dccm_wren_bank,
  input  logic [DCCM_NUM_BANKS*DCCM_ADDR_W-1:0]     c_dccm_addr_bank,
  input  logic [DCCM_NUM_BANKS*DCCM_DATA_WIDTH-1:0] c_dccm_wr_data_bank,
  input  logic [DCCM_NUM_BANKS*DCCM_ECC_WIDTH-1:0]  c_dccm_wr_ecc_bank,
  output logic [DCCM_NUM_BANKS-1:0]                 m_dccm_clken_bank,
  output logic [DCCM_NUM_BANKS-1:0]                 m_dccm_wren_bank,
  output logic [DCCM_NUM_BANKS*DCCM_ADDR_W-1:0]     m_dccm_addr_bank,
  output logic [DCCM_NUM_BANKS*DCCM_DATA_WIDTH-1:0] m_dccm_wr_data_bank,
  output logic [DCCM_NUM_BANKS*DCCM_ECC_WIDTH-1:0]  m_dccm_wr_ecc_bank
);

  localparam int CNT_W = (ICCM_ADDR_W > DCCM_ADDR_W) ? ICCM_ADDR_W : DCCM_ADDR_W;
  localparam logic [CNT_W-1:0] ICCM_LAST = CNT_W'((64'd1 << ICCM_ADDR_W) - 64'd1);
  localparam logic [CNT_W-1:0] DCCM_LAST = CNT_W'((64'd1 << DCCM_ADDR_W) - 64'd1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ICCM_FILL = 2'd1,
    DCCM_FILL = 2'd2,
    FILL_DONE = 2'd3
  } state_t;

  // Disabled arrays are skipped entirely when choosing the next fill phase.
  localparam state_t FIRST_FILL = (ICCM_ENABLE != 0) ? ICCM_FILL :
                                  (DCCM_ENABLE != 0) ? DCCM_FILL : FILL_DONE;
  localparam state_t AFTER_ICCM = (DCCM_ENABLE != 0) ? DCCM_FILL : FILL_DONE;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             first_q, first_d;
  logic             start;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      first_q <= first_d;
    end
  end

  // An init_req coinciding with the auto-start cycle merges into the same single fill.
  assign start = ((AUTO_START != 0) && first_q) || init_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    first_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FIRST_FILL;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      ICCM_FILL: begin
        if (cnt_q == ICCM_LAST) begin
          state_d = AFTER_ICCM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DCCM_FILL: begin
        if (cnt_q == DCCM_LAST) begin
          state_d = FILL_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FILL_DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

  // With ICCM_ENABLE=0 the ICCM path is never taken over, even during a DCCM fill.
  always_comb begin
    m_iccm_clken_bank   = c_iccm_clken_bank;
    m_iccm_wren_bank    = c_iccm_wren_bank;
    m_iccm_addr_bank    = c_iccm_addr_bank;
    m_iccm_wr_data_bank = c_iccm_wr_data_bank;
    m_iccm_wr_ecc_bank  = c_iccm_wr_ecc_bank;
    if ((ICCM_ENABLE != 0) && busy) begin
      if (state_q == ICCM_FILL) begin
        m_iccm_clken_bank   = '1;
        m_iccm_wren_bank    = '1;
        m_iccm_addr_bank    = {ICCM_NUM_BANKS{cnt_q[ICCM_ADDR_W-1:0]}};
        m_iccm_wr_data_bank = '0;
        m_iccm_wr_ecc_bank  = '0;
      end else begin
        m_iccm_clken_bank   = '0;
        m_iccm_wren_bank    = '0;
        m_iccm_addr_bank    = '0;
        m_iccm_wr_data_bank = '0;
        m_iccm_wr_ecc_bank  = '0;
      end
    end
    if (!rst_l) begin
      m_iccm_clken_bank = '0;
      m_iccm_wren_bank  = '0;
    end
  end

  always_comb begin
    m_dccm_clken_bank   = c_dccm_clken_bank;
    m_dccm_wren_bank    = c_dccm_wren_bank;
    m_dccm_addr_bank    = c_dccm_addr_bank;
    m_dccm_wr_data_bank = c_dccm_wr_data_bank;
    m_dccm_wr_ecc_bank  = c_dccm_wr_ecc_bank;
    if (busy) begin
      if (state_q == DCCM_FILL) begin
        m_dccm_clken_bank   = '1;
        m_dccm_wren_bank    = '1;
        m_dccm_addr_bank    = {DCCM_NUM_BANKS{cnt_q[DCCM_ADDR_W-1:0]}};
        m_dccm_wr_data_bank = '0;
        m_dccm_wr_ecc_bank  = '0;
      end else begin
        m_dccm_clken_bank   = '0;
        m_dccm_wren_bank    = '0;
        m_dccm_addr_bank    = '0;
        m_dccm_wr_data_bank = '0;
        m_dccm_wr_ecc_bank  = '0;
      end
    end
    if (!rst_l) begin
      m_dccm_clken_bank = '0;
      m_dccm_wren_bank  = '0;
    end
  end

endmodule
